// File: rtl/ifu_fetch_pkg.sv
// Shared constants and helpers for the instruction fetch stage.
package ifu_fetch_pkg;

    localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned PC_WIDTH_DEF   = 32;

    // Bits needed to hold a count from 0 up to and including n.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/ifu_fetch_fifo.sv
// Prefetch FIFO of {pc, instr} pairs; flush outranks push, head is register-driven.
module fetch_fifo
    import ifu_fetch_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned PC_WIDTH   = PC_WIDTH_DEF,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_flush,
    input  logic                           i_push,
    input  logic [PC_WIDTH-1:0]            i_push_pc,
    input  logic [DATA_WIDTH-1:0]          i_push_instr,
    input  logic                           i_pop,
    output logic [$clog2(DEPTH+1)-1:0]     o_count,
    output logic                           o_empty,
    output logic [PC_WIDTH-1:0]            o_head_pc,
    output logic [DATA_WIDTH-1:0]          o_head_instr
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = cnt_width(DEPTH);

    logic [PC_WIDTH-1:0]   r_pc    [DEPTH];
    logic [DATA_WIDTH-1:0] r_instr [DEPTH];
    logic [AW-1:0]         r_wptr;
    logic [AW-1:0]         r_rptr;
    logic [CW-1:0]         r_count;

    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_full = (r_count == CW'(DEPTH));
    assign w_pop  = i_pop && (r_count != '0);
    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign w_push = i_push && (!w_full || w_pop);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_pc[r_wptr]    <= i_push_pc;
                r_instr[r_wptr] <= i_push_instr;
                r_wptr          <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    assign o_count      = r_count;
    assign o_empty      = (r_count == '0);
    assign o_head_pc    = r_pc[r_rptr];
    assign o_head_instr = r_instr[r_rptr];

    a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst || i_flush)
        !(i_push && w_full && !w_pop));

endmodule

// File: rtl/ifu_fetch.sv
// Fetch stage: owns the PC, issues in-order imem requests under credit limits,
// drops responses orphaned by redirects and buffers the rest for decode.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter int unsigned          DATA_WIDTH      = DATA_WIDTH_DEF,
    parameter int unsigned          PC_WIDTH        = PC_WIDTH_DEF,
    parameter logic [PC_WIDTH-1:0]  RESET_PC        = PC_WIDTH'(RESET_PC_DEF),
    parameter int unsigned          FIFO_DEPTH      = 2,
    parameter int unsigned          MAX_OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [PC_WIDTH-1:0]   imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    input  logic                  redirect_valid,
    input  logic [PC_WIDTH-1:0]   redirect_pc,
    output logic                  id_valid,
    input  logic                  id_ready,
    output logic [DATA_WIDTH-1:0] id_instr,
    output logic [PC_WIDTH-1:0]   id_pc
);

    localparam int unsigned OW = cnt_width(MAX_OUTSTANDING);
    localparam int unsigned FW = cnt_width(FIFO_DEPTH);

    logic [PC_WIDTH-1:0]   r_fetch_pc;
    logic [PC_WIDTH-1:0]   r_rsp_pc;
    logic [OW-1:0]         r_live_cnt;
    logic [OW-1:0]         r_drop_cnt;

    logic [FW-1:0]         w_fifo_count;
    logic                  w_fifo_empty;
    logic [PC_WIDTH-1:0]   w_head_pc;
    logic [DATA_WIDTH-1:0] w_head_instr;
    logic [PC_WIDTH-1:0]   w_redirect_pc;
    logic                  w_credit_ok;
    logic                  w_req_fire;
    logic                  w_drop_rsp;
    logic                  w_push;
    logic                  w_pop;

    assign w_redirect_pc = redirect_pc & ~PC_WIDTH'(3);

    // Live requests reserve FIFO slots; dropped ones still occupy the memory pipe.
    assign w_credit_ok = (32'(r_live_cnt) + 32'(w_fifo_count) < 32'(FIFO_DEPTH)) &&
                         (32'(r_live_cnt) + 32'(r_drop_cnt)   < 32'(MAX_OUTSTANDING));

    assign imem_req_valid = !rst && !redirect_valid && w_credit_ok;
    assign imem_req_addr  = r_fetch_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    assign w_drop_rsp = imem_rsp_valid && (r_drop_cnt != '0);
    assign w_push     = !rst && !redirect_valid && imem_rsp_valid && (r_drop_cnt == '0);

    assign id_valid = !rst && !redirect_valid && !w_fifo_empty;
    assign w_pop    = id_valid && id_ready;
    assign id_instr = (rst || w_fifo_empty) ? DATA_WIDTH'(NOP_INSTR) : w_head_instr;
    assign id_pc    = (rst || w_fifo_empty) ? '0 : w_head_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_rsp_pc   <= RESET_PC;
            r_live_cnt <= '0;
            r_drop_cnt <= '0;
        end else if (redirect_valid) begin
            r_fetch_pc <= w_redirect_pc;
            r_rsp_pc   <= w_redirect_pc;
            r_live_cnt <= '0;
            // Everything still in the memory pipe is now stale, minus this cycle's arrival.
            r_drop_cnt <= r_live_cnt + r_drop_cnt - OW'(imem_rsp_valid);
        end else begin
            if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + PC_WIDTH'(4);
            end
            if (w_push) begin
                r_rsp_pc <= r_rsp_pc + PC_WIDTH'(4);
            end
            r_live_cnt <= r_live_cnt + OW'(w_req_fire) - OW'(w_push);
            if (w_drop_rsp) begin
                r_drop_cnt <= r_drop_cnt - 1'b1;
            end
        end
    end

    fetch_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .PC_WIDTH   (PC_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_flush      (redirect_valid),
        .i_push       (w_push),
        .i_push_pc    (r_rsp_pc),
        .i_push_instr (imem_rsp_data),
        .i_pop        (w_pop),
        .o_count      (w_fifo_count),
        .o_empty      (w_fifo_empty),
        .o_head_pc    (w_head_pc),
        .o_head_instr (w_head_instr)
    );

endmodule
